// File: rtl/lsu_pkg.sv
// lsu_pkg: LSU constants shared by the input-peripheral window and the LSU address decoder.
// Defining INPUT_PERIPH_DEBOUNCE_EN turns on per-key debouncing.
package lsu_pkg;
  typedef enum logic [1:0] {RD_SW, RD_KEY, RD_EDGE, RD_NONE} rd_sel_t;
  localparam logic [3:0] OFF_SW = 4'h0;
  localparam logic [3:0] OFF_KEY = 4'h4;
  localparam logic [3:0] OFF_EDGE = 4'h8;
  localparam int NKEY = 4;
  localparam logic [31:0] INPUT_PERIPH_BASE = 32'h0000_FF00;
`ifdef INPUT_PERIPH_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif
  function automatic rd_sel_t rd_sel(input logic [3:0] off);
    return rd_sel_t'(off[3:2]);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's debounced state and rising-edge pulse.
// The counter is only built when INPUT_PERIPH_DEBOUNCE_EN is defined.
module key_debounce import lsu_pkg::*; #(
  parameter int CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pressed_i,
  output logic db_o,
  output logic rise_o
);
  logic db_next;
  if (DEBOUNCE_EN && CYCLES > 0) begin : g_cnt
    localparam int CW = $clog2(CYCLES + 1);
    logic [CW-1:0] cnt;
    logic done;
    assign done = cnt == CW'(CYCLES - 1);
    // Count stops at CYCLES-1: the state flips there and the counter clears, so it never wraps
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt <= '0;
      else cnt <= (pressed_i == db_o || done) ? '0 : cnt + CW'(1);
    assign db_next = (done && pressed_i != db_o) ? pressed_i : db_o;
  end else begin : g_raw
    assign db_next = pressed_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) db_o <= 1'b0;
    else db_o <= db_next;
  assign rise_o = db_next & ~db_o;
endmodule

// File: rtl/input_periph.sv
// input_periph: synchronized switches, debounced keys and W1C key-press edge bits on the LSU load path.
// Key debouncing is enabled by INPUT_PERIPH_DEBOUNCE_EN.
module input_periph import lsu_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SW_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic [3:0]      key_ni,
  input  logic [3:0]      addr_i,
  input  logic            st_en_i,
  input  logic [31:0]     st_data_i,
  output logic [31:0]     input_periph_o
);
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [NKEY-1:0] key_s1, key_s2, pressed, db, rise, arm, arm_eff, clr, edges;
  logic [1:0] live;
  logic unused;
  // live marks when the synchronizer holds real samples; arm blocks edges for keys held through reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
      live <= '0;
      arm <= '0;
      edges <= '0;
    end else begin
      sw_s1 <= sw_i;
      sw_s2 <= sw_s1;
      key_s1 <= key_ni;
      key_s2 <= key_s1;
      live <= {live[0], 1'b1};
      arm <= arm_eff;
      edges <= (edges & ~clr) | (rise & arm_eff);
    end
  assign pressed = ~key_s2;
  assign arm_eff = arm | ({NKEY{live[1]}} & ~pressed);
  assign clr = (st_en_i && rd_sel(addr_i) == RD_EDGE) ? st_data_i[NKEY-1:0] : '0;
  assign unused = ^{addr_i[1:0], st_data_i[31:NKEY]};
  for (genvar k = 0; k < NKEY; k++) begin : g_key
    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .pressed_i(pressed[k]),
      .db_o(db[k]),
      .rise_o(rise[k])
    );
  end
  always_comb
    input_periph_o = rd_sel(addr_i) == RD_SW   ? 32'(sw_s2) :
                     rd_sel(addr_i) == RD_KEY  ? 32'(db) :
                     rd_sel(addr_i) == RD_EDGE ? 32'(edges) : 32'b0;
endmodule

// File: tb/tb_input_periph.sv
// tb_input_periph: directed and random stimulus against a history-based reference model.
module tb_input_periph;
  localparam int N = 4;
`ifdef INPUT_PERIPH_DEBOUNCE_EN
  localparam int W = N;
`else
  localparam int W = 1;
`endif
  logic clk = 0, rst = 1;
  logic [9:0] sw = '0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] addr = '0;
  logic st_en = 0;
  logic [31:0] st_data = '0;
  logic [31:0] rd;
  int errors = 0, checks = 0;
  int hold[4];

  input_periph #(.DEBOUNCE_CYCLES(N), .SW_W(10)) dut (
    .clk_i(clk), .rst_i(rst), .sw_i(sw), .key_ni(key_n), .addr_i(addr),
    .st_en_i(st_en), .st_data_i(st_data), .input_periph_o(rd)
  );

  always #5 clk = ~clk;

  // model: per-edge input samples since reset release, plus visible state
  logic [3:0] pr_hist[$];
  logic [9:0] sw_hist[$];
  logic [3:0] m_db = '0, m_edge = '0, m_arm = '0;
  bit m_rst = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t addr=%h)", tag, got, exp, $time, addr);
    end
  endtask

  function automatic logic [3:0] sync_at(input int j);
    return (j >= 2) ? pr_hist[j-2] : 4'h0;
  endfunction

  function automatic logic [31:0] expect_rd(input logic [3:0] a);
    int c = sw_hist.size();
    if (m_rst) return 32'h0;
    case (a[3:2])
      2'b00: return (c >= 2) ? 32'(sw_hist[c-2]) : 32'h0;
      2'b01: return 32'(m_db);
      2'b10: return 32'(m_edge);
      default: return 32'h0;
    endcase
  endfunction

  // a key's state becomes v once the last W synchronized samples all equal v
  task automatic step();
    int k = pr_hist.size();
    logic [3:0] s, t, nd, arm_eff, rise;
    bit same;
    pr_hist.push_back(~key_n);
    sw_hist.push_back(sw);
    s = sync_at(k);
    nd = m_db;
    for (int n = 0; n < 4; n++) begin
      same = 1;
      for (int j = k - W + 1; j <= k; j++) begin
        t = sync_at(j);
        if (t[n] != s[n]) same = 0;
      end
      if (same) nd[n] = s[n];
    end
    arm_eff = m_arm | ((k >= 2) ? ~s : 4'h0);
    rise = nd & ~m_db & arm_eff;
    if (st_en && addr[3:2] == 2'b10) m_edge &= ~st_data[3:0];
    m_edge |= rise;
    m_db = nd;
    m_arm = arm_eff;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) step();
    @(negedge clk);
    check(tag, rd, expect_rd(addr));
  endtask

  task automatic sweep(input string tag);
    logic [3:0] keep = addr;
    for (int a = 0; a < 16; a += 4) begin
      addr = 4'(a);
      #1 check(tag, rd, expect_rd(addr));
    end
    addr = keep;
  endtask

  task automatic do_reset();
    rst = 1;
    pr_hist.delete();
    sw_hist.delete();
    m_db = '0;
    m_edge = '0;
    m_arm = '0;
    m_rst = 1;
    #1 sweep("reset");
    @(negedge clk);
    rst = 0;
    m_rst = 0;
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick(tag);
      sweep(tag);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    sw = 10'h2A5;
    addr = 4'h0;
    tick("sw_lat1");
    tick("sw_lat2");
    check("sw_value", rd, 32'h0000_02A5);
    run("sw_hold", 2);
    key_n = 4'b1101;
    run("key1_press", 6);
    addr = 4'h4;
    #1 check("key1_db", rd, 32'h2);
    addr = 4'h8;
    #1 check("key1_edge", rd, 32'h2);
    key_n = 4'hF;
    run("key1_release", 8);
    key_n = 4'b1110;
    run("key0_glitch", 3);
    key_n = 4'hF;
    run("key0_after", 8);
    key_n = 4'b1110;
    run("key0_press", 7);
    key_n = 4'hF;
    run("key0_release", 7);
    addr = 4'h8;
    st_en = 1;
    st_data = 32'h1;
    tick("w1c_bit0");
    addr = 4'h0;
    st_data = 32'hF;
    tick("store_other_addr");
    st_en = 0;
    sweep("after_stores");
    key_n = 4'b1011;
    addr = 4'hA;
    st_en = 1;
    st_data = 32'h4;
    run("set_clear_race", 8);
    st_en = 0;
    key_n = 4'hF;
    run("key2_release", 7);
    key_n = 4'b0111;
    run("key3_pre_reset", 3);
    do_reset();
    run("key3_held", 10);
    key_n = 4'hF;
    run("key3_release", 8);
    key_n = 4'b0111;
    run("key3_repress", 8);
    key_n = 4'hF;
    run("key3_done", 6);
    for (int n = 0; n < 4; n++) hold[n] = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int n = 0; n < 4; n++) begin
        if (hold[n] == 0) begin
          key_n[n] = 1'($urandom_range(0, 1));
          hold[n] = $urandom_range(1, 9);
        end else hold[n]--;
      end
      if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
      addr = 4'($urandom);
      st_en = ($urandom_range(0, 3) == 0);
      st_data = $urandom;
      tick("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
